prompt_note_scheduler: RTL and testbench

//  Owns the single piano tone generator and schedules its use in the swctrl_piano design.
//  - Ear Training: on a MicroBlaze start pulse, plays the prompt chord (1-3 note IDs) as a timed

---
 rtl/prompt_note_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_prompt_note_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prompt_note_scheduler.sv
// Arbitrates the single piano tone generator: plays a latched 1-3 note prompt as a timed
// arpeggio in Ear Training, otherwise forwards the live keyboard note.
module prompt_note_scheduler #(
  parameter int TICK_DIV = 100000,
  parameter int NOTE_MS  = 500,
  parameter int GAP_MS   = 100
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESET,
  input  logic [1:0] mode_sel,
  input  logic       start,
  input  logic [1:0] play_note_num,
  input  logic [6:0] play_note_id_0,
  input  logic [6:0] play_note_id_1,
  input  logic [6:0] play_note_id_2,
  input  logic       key_valid,
  input  logic [6:0] key_note_id,
  output logic       tone_en,
  output logic [6:0] tone_note_id,
  output logic       busy,
  output logic       done,
  output logic       src_prompt,
  output logic [1:0] note_idx
);

  localparam int NOTE_CLK = NOTE_MS * TICK_DIV;
  localparam int GAP_CLK  = GAP_MS * TICK_DIV;
  localparam int MAX_CLK  = (NOTE_CLK > GAP_CLK) ? NOTE_CLK : GAP_CLK;
  localparam int CNT_W    = (MAX_CLK > 1) ? $clog2(MAX_CLK) : 1;

  localparam logic [1:0] MODE_EAR  = 2'd1;
  localparam logic [1:0] MODE_FREE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_FINISH
  } state_t;

  state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0] num_q;
  logic [6:0] id0_q, id1_q, id2_q;

  logic       tone_en_q;
  logic [6:0] tone_note_id_q;
  logic       busy_q;
  logic       done_q;
  logic       src_prompt_q;
  logic [1:0] note_idx_q;

  logic [6:0] next_id_d;
  logic       note_end_d;
  logic       gap_end_d;
  logic       last_note_d;
  logic       abort_d;

  always_comb begin
    next_id_d = 7'd0;
    case (note_idx_q)
      2'd0:    next_id_d = id1_q;
      2'd1:    next_id_d = id2_q;
      default: next_id_d = 7'd0;
    endcase
  end

  assign note_end_d  = (cnt_q == CNT_W'(NOTE_CLK - 1));
  assign gap_end_d   = (cnt_q == CNT_W'(GAP_CLK - 1));
  assign last_note_d = (note_idx_q == (num_q - 2'd1));
  // Leaving Ear Training cancels the prompt immediately, even on an expiry cycle.
  assign abort_d     = (mode_sel != MODE_EAR);

  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      num_q          <= 2'd0;
      id0_q          <= 7'd0;
      id1_q          <= 7'd0;
      id2_q          <= 7'd0;
      tone_en_q      <= 1'b0;
      tone_note_id_q <= 7'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      src_prompt_q   <= 1'b0;
      note_idx_q     <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q      <= '0;
          note_idx_q <= 2'd0;
          if (start && mode_sel == MODE_EAR) begin
            num_q <= play_note_num;
            id0_q <= play_note_id_0;
            id1_q <= play_note_id_1;
            id2_q <= play_note_id_2;
            if (play_note_num != 2'd0) begin
              state_q        <= S_PLAY;
              busy_q         <= 1'b1;
              src_prompt_q   <= 1'b1;
              tone_note_id_q <= play_note_id_0;
              tone_en_q      <= (play_note_id_0 != 7'd0);
            end else begin
              state_q      <= S_FINISH;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              src_prompt_q <= 1'b0;
              tone_en_q    <= 1'b0;
            end
          end else if (mode_sel == MODE_EAR || mode_sel == MODE_FREE) begin
            tone_en_q      <= key_valid;
            tone_note_id_q <= key_note_id;
          end else begin
            tone_en_q      <= 1'b0;
            tone_note_id_q <= 7'd0;
          end
        end

        S_PLAY: begin
          if (abort_d) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tone_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            src_prompt_q <= 1'b0;
            note_idx_q   <= 2'd0;
          end else if (note_end_d) begin
            cnt_q     <= '0;
            tone_en_q <= 1'b0;
            if (last_note_d) begin
              state_q      <= S_FINISH;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              src_prompt_q <= 1'b0;
            end else begin
              state_q <= S_GAP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (abort_d) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tone_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            src_prompt_q <= 1'b0;
            note_idx_q   <= 2'd0;
          end else if (gap_end_d) begin
            state_q        <= S_PLAY;
            cnt_q          <= '0;
            note_idx_q     <= note_idx_q + 2'd1;
            tone_note_id_q <= next_id_d;
            tone_en_q      <= (next_id_d != 7'd0);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          // FINISH: a start here is deliberately dropped; passthrough resumes after IDLE is reached.
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          tone_en_q    <= 1'b0;
          busy_q       <= 1'b0;
          src_prompt_q <= 1'b0;
          note_idx_q   <= 2'd0;
        end
      endcase
    end
  end

  assign tone_en      = tone_en_q;
  assign tone_note_id = tone_note_id_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign src_prompt   = src_prompt_q;
  assign note_idx     = note_idx_q;

endmodule

// File: tb/tb_prompt_note_scheduler.sv
// Directed plus randomized bench for prompt_note_scheduler; expected outputs come from a
// timeline model (elapsed cycles since accept mapped onto note/gap slots).
module tb_prompt_note_scheduler;

  localparam int TICK_DIV = 4;
  localparam int NOTE_MS  = 3;
  localparam int GAP_MS   = 2;
  localparam int NC  = NOTE_MS * TICK_DIV;
  localparam int GC  = GAP_MS * TICK_DIV;
  localparam int PER = NC + GC;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       start;
  logic [1:0] num;
  logic [6:0] id0, id1, id2;
  logic       kv;
  logic [6:0] kid;

  logic       tone_en;
  logic [6:0] tone_note_id;
  logic       busy;
  logic       done;
  logic       src_prompt;
  logic [1:0] note_idx;

  prompt_note_scheduler #(
    .TICK_DIV(TICK_DIV),
    .NOTE_MS (NOTE_MS),
    .GAP_MS  (GAP_MS)
  ) dut (
    .CLK100MHZ     (clk),
    .CPU_RESET     (rst),
    .mode_sel      (mode),
    .start         (start),
    .play_note_num (num),
    .play_note_id_0(id0),
    .play_note_id_1(id1),
    .play_note_id_2(id2),
    .key_valid     (kv),
    .key_note_id   (kid),
    .tone_en       (tone_en),
    .tone_note_id  (tone_note_id),
    .busy          (busy),
    .done          (done),
    .src_prompt    (src_prompt),
    .note_idx      (note_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  // Reference model state
  bit         m_active;
  bit         m_fin;
  int         m_t;
  int         m_num;
  logic [6:0] m_ids [3];
  logic       e_en, e_busy, e_done, e_src;
  logic [6:0] e_id;
  logic [1:0] e_idx;

  task automatic idle_outputs();
    e_en = 1'b0; e_busy = 1'b0; e_src = 1'b0; e_idx = 2'd0; e_id = 7'd0;
  endtask

  // Expected outputs after the coming edge, from the inputs being presented now.
  task automatic model_update();
    int k, w, total;
    e_done = 1'b0;
    if (rst) begin
      m_active = 0; m_fin = 0;
      idle_outputs();
    end else if (m_active) begin
      if (mode != 2'd1) begin
        m_active = 0;
        idle_outputs();
      end else begin
        m_t++;
        total = m_num * NC + (m_num - 1) * GC;
        if (m_t == total) begin
          m_active = 0; m_fin = 1;
          idle_outputs();
          e_done = 1'b1;
        end else begin
          k = m_t / PER;
          w = m_t % PER;
          e_busy = 1'b1; e_src = 1'b1; e_idx = k[1:0];
          if (w < NC) begin
            e_en = (m_ids[k] != 7'd0);
            e_id = m_ids[k];
          end else begin
            e_en = 1'b0;
          end
        end
      end
    end else if (m_fin) begin
      m_fin = 0;
      idle_outputs();
    end else if (start && mode == 2'd1) begin
      m_num = int'(num);
      m_ids[0] = id0; m_ids[1] = id1; m_ids[2] = id2;
      idle_outputs();
      if (num == 2'd0) begin
        m_fin = 1;
        e_done = 1'b1;
      end else begin
        m_active = 1; m_t = 0;
        e_busy = 1'b1; e_src = 1'b1;
        e_en = (id0 != 7'd0);
        e_id = id0;
      end
    end else begin
      idle_outputs();
      e_en = (mode == 2'd1 || mode == 2'd2) && kv;
      e_id = kid;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("tone_en", {6'd0, tone_en}, {6'd0, e_en});
    chk("busy", {6'd0, busy}, {6'd0, e_busy});
    chk("done", {6'd0, done}, {6'd0, e_done});
    chk("src_prompt", {6'd0, src_prompt}, {6'd0, e_src});
    if (!e_done) chk("note_idx", {5'd0, note_idx}, {5'd0, e_idx});
    if (e_en) chk("tone_note_id", tone_note_id, e_id);
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; mode = 2'd1; start = 1'b1; num = 2'd2;
    id0 = 7'd27; id1 = 7'd31; id2 = 7'd0; kv = 1'b1; kid = 7'd9;

    // Reset held with key and start active
    steps(3);
    rst = 1'b0; start = 1'b0; kv = 1'b0;
    steps(2);

    // Two-note prompt 27/31
    busy_cnt = 0; done_cnt = 0;
    start = 1'b1; step();
    start = 1'b0; steps(40);
    chk("busy_cycles_2note", 7'(busy_cnt), 7'd32);
    chk("done_pulses_2note", 7'(done_cnt), 7'd1);

    // Zero-note prompt
    busy_cnt = 0; done_cnt = 0;
    num = 2'd0; start = 1'b1; step();
    start = 1'b0; steps(3);
    chk("busy_cycles_0note", 7'(busy_cnt), 7'd0);
    chk("done_pulses_0note", 7'(done_cnt), 7'd1);

    // Free Play passthrough; start ignored in mode 2
    mode = 2'd2; kv = 1'b1; kid = 7'd40; steps(2);
    num = 2'd2; start = 1'b1; step();
    start = 1'b0; steps(2);
    mode = 2'd0; steps(2);

    // Busy prompt ignores a held key
    mode = 2'd1; kv = 1'b0; steps(1);
    id0 = 7'd60; id1 = 7'd62; start = 1'b1; step();
    start = 1'b0; kv = 1'b1; kid = 7'd45; steps(36);
    kv = 1'b0;

    // Three notes 27/0/30, abort during third note
    busy_cnt = 0; done_cnt = 0;
    num = 2'd3; id0 = 7'd27; id1 = 7'd0; id2 = 7'd30;
    start = 1'b1; step();
    start = 1'b0; steps(45);
    mode = 2'd2; kv = 1'b1; kid = 7'd50; steps(4);
    chk("done_pulses_abort", 7'(done_cnt), 7'd0);

    // start held high through a playback and its FINISH cycle, then retriggered
    mode = 2'd1; kv = 1'b0; steps(1);
    done_cnt = 0;
    num = 2'd1; id0 = 7'd33; start = 1'b1;
    steps(14);
    chk("done_pulses_held", 7'(done_cnt), 7'd1);
    step();
    start = 1'b0; steps(15);
    chk("done_pulses_retrig", 7'(done_cnt), 7'd2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 99) < 3) mode = 2'd1;
      start = ($urandom_range(0, 9) == 0);
      num   = 2'($urandom_range(0, 3));
      id0   = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      id1   = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      id2   = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      kv    = 1'($urandom_range(0, 1));
      kid   = 7'($urandom_range(0, 127));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
